acumulador_q22: RTL and testbench
=================================

ACUMULADOR_Q22 -- requirements
Module: acumulador_q22

Interface
REQ-001 SHALL have parameter N_SAMPLES, default 8, meaning number of sums accepted per accumulation run (legal range 1..255).
REQ-002 SHALL have parameter ACC_W, default 10, meaning accumulator width in bits (legal range 6..16).
REQ-003 SHALL have port clk, input, 1, meaning the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst, input, 1, meaning reset; it is synchronous and active-high.
REQ-005 SHALL have port start, input, 1, meaning a request to begin a run; sampled only in IDLE.
REQ-006 SHALL have port in_valid, input, 1, meaning in_sum carries a valid 6-bit adder result.
REQ-007 SHALL have port in_sum, input, 6, meaning the unsigned sum produced by the upstream 5-bit adder stage (0..62).
REQ-008 SHALL have port in_ready, output, 1, meaning the block accepts in_sum this cycle.
REQ-009 SHALL have port acc, output, ACC_W, meaning the running or final accumulated value.
REQ-010 SHALL have port count, output, 8, meaning the number of samples accepted in the current run.
REQ-011 SHALL have port ovf, output, 1, meaning sticky saturation flag for the current run.
REQ-012 SHALL have port out_valid, output, 1, meaning acc, count and ovf hold a completed result.
REQ-013 SHALL have port out_ready, input, 1, meaning the downstream consumer takes the result.

Function
REQ-014 SHALL implement a three-state FSM: IDLE, ACCUM, DONE.
REQ-015 SHALL in IDLE with start=1: clear acc, count and ovf to 0 and move to ACCUM on the next edge.
REQ-016 SHALL in IDLE with start=0: hold acc, count and ovf unchanged (last result stays visible).
REQ-017 SHALL drive in_ready=1 only in ACCUM; 0 in IDLE and DONE.
REQ-018 SHALL accept a sample exactly on cycles where in_valid=1 and in_ready=1; no other cycle changes acc or count.
REQ-019 SHALL on acceptance zero-extend in_sum to ACC_W bits and add it to acc; count increments by 1.
REQ-020 SHALL saturate acc at 2^ACC_W-1 when the sum exceeds it, setting ovf=1; ovf stays 1 until the next start or rst.
REQ-021 SHALL move ACCUM->DONE on the edge that accepts sample number N_SAMPLES; acc already includes that sample in DONE.
REQ-022 SHALL drive out_valid=1 in DONE only; acc, count and ovf are stable while out_valid=1.
REQ-023 SHALL move DONE->IDLE on the edge where out_valid=1 and out_ready=1; out_valid is 0 the following cycle.
REQ-024 SHALL ignore start in ACCUM and DONE (no clear, no restart), including start and out_ready high in the same DONE cycle.
REQ-025 SHALL ignore in_valid outside ACCUM; a sample presented then is not counted.
REQ-026 SHALL have zero bubble: with in_valid held at 1, N_SAMPLES samples are accepted in N_SAMPLES consecutive cycles, out_valid rising the cycle after the last.
REQ-027 SHALL be fully synchronous with no combinational path from in_valid or out_ready to any output except none; in_ready and out_valid depend on state only.

Reset
REQ-028 SHALL on rst=1 at a rising edge set state=IDLE, acc=0, count=0, ovf=0, out_valid=0, in_ready=0.
REQ-029 SHALL let rst take priority over start, in_valid and out_ready in the same cycle.
REQ-030 SHALL abort a run on rst asserted mid-ACCUM or in DONE; partial acc is discarded (reads 0).

Verification
REQ-031 SHALL cover: rst, start, 8 consecutive valid samples of 62 (defaults) -> out_valid after 8th accept, acc=496, count=8, ovf=0.
REQ-032 SHALL cover: ACC_W=8, N_SAMPLES=8, eight samples of 62 -> acc=255, ovf=1, count=8; next start -> ovf=0, acc=0.
REQ-033 SHALL cover: in_valid toggling 1,0,1,0... with in_sum=5 -> only valid cycles counted; after 8 accepts acc=40.
REQ-034 SHALL cover: DONE with out_ready=0 for 5 cycles -> out_valid stays 1, acc unchanged; out_ready=1 -> IDLE next cycle; start in same cycle ignored.
REQ-035 SHALL cover: rst pulsed after 3 accepted samples of 10 -> acc=0, count=0, IDLE; in_valid afterwards without start -> not counted.
REQ-036 SHALL cover: start while in ACCUM after 2 samples of 7 -> acc stays 14, count stays 2, run continues to N_SAMPLES.

Source files
------------

// File: rtl/acumulador_q22.sv
// acumulador_q22 -- accumulates a run of 6-bit adder results into a saturating
// ACC_W-bit sum.
//
// Ports
//   clk        in   rising-edge clock for all state
//   rst        in   synchronous, active-high reset
//   start      in   begin a run (looked at in IDLE only)
//   in_valid   in   in_sum carries a valid sample
//   in_sum     in   [5:0] unsigned sample from the upstream 5-bit adder (0..62)
//   in_ready   out  samples are accepted this cycle (ACCUM only)
//   acc        out  [ACC_W-1:0] running / final accumulated value
//   count      out  [7:0] samples accepted in the current run
//   ovf        out  sticky saturation flag for the current run
//   out_valid  out  acc/count/ovf hold a completed result (DONE only)
//   out_ready  in   downstream takes the result
//
// Parameters
//   N_SAMPLES  samples per run (1..255)
//   ACC_W      accumulator width (6..16)

module acumulador_q22 #(
    parameter int unsigned N_SAMPLES = 8,
    parameter int unsigned ACC_W     = 10
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             in_valid,
    input  logic [5:0]       in_sum,
    output logic             in_ready,
    output logic [ACC_W-1:0] acc,
    output logic [7:0]       count,
    output logic             ovf,
    output logic             out_valid,
    input  logic             out_ready
);

    localparam int unsigned SUM_W = ACC_W + 1;
    localparam logic [7:0]  LAST  = 8'(N_SAMPLES - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [ACC_W-1:0]   acc_q, acc_d;
    logic [7:0]         count_q, count_d;
    logic               ovf_q, ovf_d;
    logic               in_ready_q, in_ready_d;
    logic               out_valid_q, out_valid_d;
    logic [SUM_W-1:0]   sum_ext;

    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        count_d = count_q;
        ovf_d   = ovf_q;
        // One extra bit catches the carry out of the accumulator.
        sum_ext = {1'b0, acc_q} + SUM_W'(in_sum);

        case (state_q)
            IDLE: begin
                if (start) begin
                    acc_d   = '0;
                    count_d = '0;
                    ovf_d   = 1'b0;
                    state_d = ACCUM;
                end
            end
            ACCUM: begin
                // in_ready is 1 throughout ACCUM, so in_valid alone marks acceptance.
                if (in_valid) begin
                    if (sum_ext[ACC_W]) begin
                        acc_d = '1;
                        ovf_d = 1'b1;
                    end else begin
                        acc_d = sum_ext[ACC_W-1:0];
                    end
                    count_d = count_q + 8'd1;
                    if (count_q == LAST) begin
                        state_d = DONE;
                    end
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        // Handshake outputs are registered copies of the next-state decode.
        in_ready_d  = (state_d == ACCUM);
        out_valid_d = (state_d == DONE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            acc_q       <= '0;
            count_q     <= '0;
            ovf_q       <= 1'b0;
            in_ready_q  <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            acc_q       <= acc_d;
            count_q     <= count_d;
            ovf_q       <= ovf_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign acc       = acc_q;
    assign count     = count_q;
    assign ovf       = ovf_q;

endmodule

// File: tb/tb_acumulador_q22.sv
// Bench for acumulador_q22: a default instance (ACC_W=10) and a narrow
// instance (ACC_W=8) share one stimulus stream; a vector table covers the
// long runs and hand sequences cover hold / abort / restart corners.

module tb_acumulador_q22;

    logic       clk = 1'b0;
    logic       rst, start, in_valid, out_ready;
    logic [5:0] in_sum;

    logic       a_in_ready, a_ovf, a_out_valid;
    logic [9:0] a_acc;
    logic [7:0] a_count;
    logic       b_in_ready, b_ovf, b_out_valid;
    logic [7:0] b_acc;
    logic [7:0] b_count;

    int tests  = 0;
    int failed = 0;

    acumulador_q22 #(.N_SAMPLES(8), .ACC_W(10)) dut_a (
        .clk(clk), .rst(rst), .start(start), .in_valid(in_valid), .in_sum(in_sum),
        .in_ready(a_in_ready), .acc(a_acc), .count(a_count), .ovf(a_ovf),
        .out_valid(a_out_valid), .out_ready(out_ready)
    );

    acumulador_q22 #(.N_SAMPLES(8), .ACC_W(8)) dut_b (
        .clk(clk), .rst(rst), .start(start), .in_valid(in_valid), .in_sum(in_sum),
        .in_ready(b_in_ready), .acc(b_acc), .count(b_count), .ovf(b_ovf),
        .out_valid(b_out_valid), .out_ready(out_ready)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       rst, start, in_valid;
        logic [5:0] in_sum;
        logic       out_ready;
        logic       e_ready, e_valid;
        int         e_acc, e_cnt;
        logic       e_ovf;
        int         eb_acc;
        logic       eb_ovf;
    } vec_t;

    vec_t vecs[$];

    function automatic void add(input logic r, input logic s, input logic iv, input int sum,
                                input logic ordy, input logic er, input logic ev,
                                input int ea, input int ec, input logic eo,
                                input int eba, input logic ebo);
        vec_t v;
        v.rst = r; v.start = s; v.in_valid = iv; v.in_sum = 6'(sum); v.out_ready = ordy;
        v.e_ready = er; v.e_valid = ev; v.e_acc = ea; v.e_cnt = ec; v.e_ovf = eo;
        v.eb_acc = eba; v.eb_ovf = ebo;
        vecs.push_back(v);
    endfunction

    task automatic check(input string name, input int got, input int exp);
        tests++;
        if (got != exp) begin
            failed++;
            $display("FAIL %s: got %0d expected %0d", name, got, exp);
        end
    endtask

    task automatic step(input logic r, input logic s, input logic iv, input int sum,
                        input logic ordy);
        rst = r; start = s; in_valid = iv; in_sum = 6'(sum); out_ready = ordy;
        @(posedge clk);
        #1;
    endtask

    task automatic chk_a(input string tag, input logic er, input logic ev,
                         input int ea, input int ec, input logic eo);
        check({tag, ".in_ready"}, int'(a_in_ready), int'(er));
        check({tag, ".out_valid"}, int'(a_out_valid), int'(ev));
        check({tag, ".acc"}, int'(a_acc), ea);
        check({tag, ".count"}, int'(a_count), ec);
        check({tag, ".ovf"}, int'(a_ovf), int'(eo));
    endtask

    initial begin
        int cnt;
        int acc62;

        // ---- Table: defaults run of 62s, saturating narrow instance, toggled 5s.
        add(1, 0, 0, 0, 0,  0, 0, 0, 0, 0,  0, 0);
        add(0, 1, 0, 0, 0,  1, 0, 0, 0, 0,  0, 0);
        for (int k = 1; k <= 8; k++) begin
            acc62 = 62 * k;
            add(0, 0, 1, 62, 0, k < 8, k == 8, acc62, k, 0,
                (acc62 > 255) ? 255 : acc62, acc62 > 255);
        end
        add(0, 0, 1, 62, 0,  0, 1, 496, 8, 0,  255, 1);   // DONE: sample ignored
        add(0, 0, 0, 0,  1,  0, 0, 496, 8, 0,  255, 1);   // consumed -> IDLE
        add(0, 0, 1, 9,  0,  0, 0, 496, 8, 0,  255, 1);   // IDLE: sample ignored
        add(0, 1, 0, 0,  0,  1, 0, 0,   0, 0,  0,   0);   // restart clears ovf
        cnt = 0;
        for (int i = 0; i < 16; i++) begin
            if (i % 2 == 0 && cnt < 8) cnt++;
            add(0, 0, (i % 2 == 0), 5, 0, cnt < 8, cnt == 8, 5 * cnt, cnt, 0, 5 * cnt, 0);
        end
        add(0, 0, 0, 0, 1,  0, 0, 40, 8, 0,  40, 0);

        foreach (vecs[i]) begin
            string tag;
            tag = $sformatf("vec%0d", i);
            step(vecs[i].rst, vecs[i].start, vecs[i].in_valid, int'(vecs[i].in_sum),
                 vecs[i].out_ready);
            chk_a(tag, vecs[i].e_ready, vecs[i].e_valid, vecs[i].e_acc, vecs[i].e_cnt,
                  vecs[i].e_ovf);
            check({tag, ".b_acc"}, int'(b_acc), vecs[i].eb_acc);
            check({tag, ".b_ovf"}, int'(b_ovf), int'(vecs[i].eb_ovf));
            check({tag, ".b_count"}, int'(b_count), vecs[i].e_cnt);
        end

        // ---- DONE held 5 cycles, then out_ready with start in the same cycle.
        step(0, 1, 0, 0, 0);
        for (int k = 1; k <= 8; k++) step(0, 0, 1, 3, 0);
        chk_a("done_entry", 0, 1, 24, 8, 0);
        for (int k = 0; k < 5; k++) begin
            step(0, 0, 1, 7, 0);
            chk_a($sformatf("done_hold%0d", k), 0, 1, 24, 8, 0);
        end
        step(0, 1, 0, 0, 1);
        chk_a("done_release", 0, 0, 24, 8, 0);
        step(0, 0, 0, 0, 0);
        chk_a("start_ignored_in_done", 0, 0, 24, 8, 0);

        // ---- rst after 3 samples of 10; later samples without start not counted.
        step(0, 1, 0, 0, 0);
        for (int k = 1; k <= 3; k++) step(0, 0, 1, 10, 0);
        chk_a("three_tens", 1, 0, 30, 3, 0);
        step(1, 1, 1, 10, 1);
        chk_a("mid_rst", 0, 0, 0, 0, 0);
        for (int k = 0; k < 3; k++) begin
            step(0, 0, 1, 10, 0);
            chk_a($sformatf("post_rst%0d", k), 0, 0, 0, 0, 0);
        end

        // ---- start during ACCUM after 2 samples of 7 is ignored.
        step(0, 1, 0, 0, 0);
        step(0, 0, 1, 7, 0);
        step(0, 0, 1, 7, 0);
        chk_a("two_sevens", 1, 0, 14, 2, 0);
        step(0, 1, 0, 0, 0);
        chk_a("start_in_accum", 1, 0, 14, 2, 0);
        for (int k = 3; k <= 8; k++) step(0, 0, 1, 7, 0);
        chk_a("run_continues", 0, 1, 56, 8, 0);

        // ---- rst in DONE discards the result.
        step(1, 0, 0, 0, 0);
        chk_a("rst_in_done", 0, 0, 0, 0, 0);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
